// File: rtl/ddr3_req_queue_pkg.sv
// rtl/ddr3_req_queue_pkg.sv - shared DDR3 request types and CPU address field positions
// Contents:
//   geometry localparams (address, row, bank, column, burst widths)
//   CPU byte-address field positions for column / bank / row
//   ddr3_req_t : a decoded request as it sits in the queue
package ddr3_req_queue_pkg;

    localparam int ADDR_MCTRL = 32;
    localparam int DQ_BITS    = 16;
    localparam int BURST_L    = 4;
    localparam int DATA_BITS  = BURST_L * DQ_BITS;
    localparam int ROW_BITS   = 14;
    localparam int BA_BITS    = 3;
    localparam int COL_BITS   = 10;

    // Column keeps addr[9:3] and forces the low three bits to zero,
    // so every command is burst aligned.
    localparam int COL_LSB  = 3;
    localparam int COL_MSB  = 9;
    localparam int BANK_LSB = 10;
    localparam int BANK_MSB = 12;
    localparam int ROW_LSB  = 13;
    localparam int ROW_MSB  = 26;

    typedef struct packed {
        logic                 we;
        logic [ROW_BITS-1:0]  row;
        logic [BA_BITS-1:0]   bank;
        logic [COL_BITS-1:0]  col;
        logic [DATA_BITS-1:0] wdata;
    } ddr3_req_t;

endpackage

// File: rtl/ddr3_addr_decode.sv
// rtl/ddr3_addr_decode.sv - combinational CPU byte address to row/bank/column split
// Ports:
//   addr : CPU byte address
//   row  : row address field
//   bank : bank address field
//   col  : burst-aligned column address
//   err  : address lies above the highest mapped bit
module ddr3_addr_decode
    import ddr3_req_queue_pkg::*;
#(
    parameter int MAX_ROW_ADDR_MSB = 26
) (
    input  logic [ADDR_MCTRL-1:0] addr,
    output logic [ROW_BITS-1:0]   row,
    output logic [BA_BITS-1:0]    bank,
    output logic [COL_BITS-1:0]   col,
    output logic                  err
);

    // The three byte-offset bits inside a burst carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[COL_LSB-1:0];

    assign col  = {addr[COL_MSB:COL_LSB], 3'b000};
    assign bank = addr[BANK_MSB:BANK_LSB];
    assign row  = addr[ROW_MSB:ROW_LSB];

    // Shift form stays legal even when the mapped region covers all 32 bits.
    assign err = (addr >> (MAX_ROW_ADDR_MSB + 1)) != '0;

endmodule

// File: rtl/ddr3_req_queue.sv
// rtl/ddr3_req_queue.sv - in-order CPU request queue feeding the DDR3 controller FSM
// Ports:
//   clock, reset_n                       : clock, synchronous active-low reset
//   i_req_valid/o_req_ready              : CPU request handshake
//   i_req_we/i_req_addr/i_req_wdata      : CPU request payload
//   o_cmd_valid/i_cmd_ready              : decoded command handshake to controller
//   o_cmd_we/row/bank/col/wdata          : registered head-of-queue command
//   o_count                              : current occupancy
//   o_addr_err                           : one-cycle pulse for a dropped out-of-range request
module ddr3_req_queue
    import ddr3_req_queue_pkg::*;
#(
    parameter int DEPTH            = 4,
    parameter int MAX_ROW_ADDR_MSB = 26
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic                         i_req_we,
    input  logic [ADDR_MCTRL-1:0]        i_req_addr,
    input  logic [DATA_BITS-1:0]         i_req_wdata,
    output logic                         o_cmd_valid,
    input  logic                         i_cmd_ready,
    output logic                         o_cmd_we,
    output logic [ROW_BITS-1:0]          o_cmd_row,
    output logic [BA_BITS-1:0]           o_cmd_bank,
    output logic [COL_BITS-1:0]          o_cmd_col,
    output logic [DATA_BITS-1:0]         o_cmd_wdata,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_addr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t              state;
    ddr3_req_t           mem [DEPTH];
    ddr3_req_t           new_req;
    ddr3_req_t           head_d;
    ddr3_req_t           head_q;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       next_rd;
    logic [CW-1:0]       count;
    logic [CW-1:0]       next_count;
    logic [ROW_BITS-1:0] dec_row;
    logic [BA_BITS-1:0]  dec_bank;
    logic [COL_BITS-1:0] dec_col;
    logic                dec_err;
    logic                accept;
    logic                push;
    logic                pop;

    ddr3_addr_decode #(
        .MAX_ROW_ADDR_MSB(MAX_ROW_ADDR_MSB)
    ) u_decode (
        .addr (i_req_addr),
        .row  (dec_row),
        .bank (dec_bank),
        .col  (dec_col),
        .err  (dec_err)
    );

    assign new_req = '{we: i_req_we, row: dec_row, bank: dec_bank,
                       col: dec_col, wdata: i_req_wdata};

    // An out-of-range request still completes its handshake; it just never lands.
    assign accept = i_req_valid & o_req_ready;
    assign push   = accept & ~dec_err;
    assign pop    = o_cmd_valid & i_cmd_ready;

    always_comb begin
        next_rd    = pop ? rd_ptr + PW'(1) : rd_ptr;
        next_count = count + CW'(push) - CW'(pop);
        // The entry being written this edge becomes the head when the queue
        // is otherwise empty after the pop; storage has not caught it yet.
        head_d     = (push && (wr_ptr == next_rd)) ? new_req : mem[next_rd];
    end

    // Storage carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= new_req;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_EMPTY;
            o_cmd_valid <= 1'b0;
            o_addr_err  <= 1'b0;
            o_req_ready <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            head_q      <= '0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(push);
            rd_ptr      <= next_rd;
            count       <= next_count;
            o_req_ready <= next_count != CW'(DEPTH);
            o_addr_err  <= accept & dec_err;
            case (state)
                S_EMPTY: begin
                    if (push) begin
                        state       <= S_HOLD;
                        o_cmd_valid <= 1'b1;
                        head_q      <= head_d;
                    end
                end
                S_HOLD: begin
                    if (next_count == '0) begin
                        state       <= S_EMPTY;
                        o_cmd_valid <= 1'b0;
                    end else begin
                        head_q      <= head_d;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    o_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_we    = head_q.we;
    assign o_cmd_row   = head_q.row;
    assign o_cmd_bank  = head_q.bank;
    assign o_cmd_col   = head_q.col;
    assign o_cmd_wdata = head_q.wdata;
    assign o_count     = count;

endmodule

// File: tb/tb_ddr3_req_queue.sv
// tb/tb_ddr3_req_queue.sv - self-checking bench for ddr3_req_queue
module tb_ddr3_req_queue;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [63:0] i_req_wdata;
    logic        o_cmd_valid;
    logic        i_cmd_ready;
    logic        o_cmd_we;
    logic [13:0] o_cmd_row;
    logic [2:0]  o_cmd_bank;
    logic [9:0]  o_cmd_col;
    logic [63:0] o_cmd_wdata;
    logic [2:0]  o_count;
    logic        o_addr_err;

    ddr3_req_queue #(.DEPTH(DEPTH), .MAX_ROW_ADDR_MSB(26)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd_we    (o_cmd_we),
        .o_cmd_row   (o_cmd_row),
        .o_cmd_bank  (o_cmd_bank),
        .o_cmd_col   (o_cmd_col),
        .o_cmd_wdata (o_cmd_wdata),
        .o_count     (o_count),
        .o_addr_err  (o_addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [63:0] wdata;
    } req_t;

    req_t q[$];
    bit   m_ready;
    bit   m_err;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected fields straight from the address map: column is the burst
    // aligned byte offset within a 1 KiB page, bank the next 3 bits, row above.
    function automatic logic [63:0] exp_row(input logic [31:0] a);
        return 64'((a / 32'd8192) % 32'd16384);
    endfunction
    function automatic logic [63:0] exp_bank(input logic [31:0] a);
        return 64'((a / 32'd1024) % 32'd8);
    endfunction
    function automatic logic [63:0] exp_col(input logic [31:0] a);
        return 64'(((a % 32'd1024) / 32'd8) * 32'd8);
    endfunction

    task automatic compare();
        chk("cmd_valid", 64'(o_cmd_valid), 64'(q.size() != 0));
        chk("count", 64'(o_count), 64'(q.size()));
        chk("req_ready", 64'(o_req_ready), 64'(m_ready));
        chk("addr_err", 64'(o_addr_err), 64'(m_err));
        if (q.size() != 0) begin
            chk("cmd_we", 64'(o_cmd_we), 64'(q[0].we));
            chk("cmd_row", 64'(o_cmd_row), exp_row(q[0].addr));
            chk("cmd_bank", 64'(o_cmd_bank), exp_bank(q[0].addr));
            chk("cmd_col", 64'(o_cmd_col), exp_col(q[0].addr));
            chk("cmd_wdata", o_cmd_wdata, q[0].wdata);
        end
    endtask

    task automatic cycle(input bit v, input bit we, input logic [31:0] a,
                         input logic [63:0] d, input bit cr);
        bit   acc;
        bit   bad;
        bit   popm;
        req_t r;
        i_req_valid = v;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wdata = d;
        i_cmd_ready = cr;
        acc  = v && m_ready;
        bad  = a >= 32'h0800_0000;
        popm = (q.size() != 0) && cr;
        @(posedge clock);
        #1;
        if (popm) void'(q.pop_front());
        if (acc && !bad) begin
            r.we = we; r.addr = a; r.wdata = d;
            q.push_back(r);
        end
        m_err   = acc && bad;
        m_ready = q.size() != DEPTH;
        compare();
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        i_req_valid = 1'b0;
        i_cmd_ready = 1'b0;
        @(posedge clock);
        #1;
        q.delete();
        m_ready = 1'b0;
        m_err   = 1'b0;
        compare();
        chk("rst_we", 64'(o_cmd_we), 64'd0);
        chk("rst_row", 64'(o_cmd_row), 64'd0);
        chk("rst_bank", 64'(o_cmd_bank), 64'd0);
        chk("rst_col", 64'(o_cmd_col), 64'd0);
        chk("rst_wdata", o_cmd_wdata, 64'd0);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        return $urandom & 32'h07FF_FFFF;
    endfunction

    function automatic logic [63:0] rand_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        reset_n     = 1'b0;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_cmd_ready = 1'b0;
        m_ready     = 1'b0;
        m_err       = 1'b0;

        do_reset();
        do_reset();
        cycle(0, 0, 0, 0, 0);
        chk("ready_after_release", 64'(o_req_ready), 64'd1);

        // Single write into an empty queue, known decode.
        cycle(1, 1, 32'h0000_2C48, 64'h0123_4567_89AB_CDEF, 0);
        chk("dir_row", 64'(o_cmd_row), 64'd1);
        chk("dir_bank", 64'(o_cmd_bank), 64'd3);
        chk("dir_col", 64'(o_cmd_col), 64'h048);
        chk("dir_we", 64'(o_cmd_we), 64'd1);
        chk("dir_wdata", o_cmd_wdata, 64'h0123_4567_89AB_CDEF);
        cycle(0, 0, 0, 0, 1);

        // Fill to DEPTH, fifth request held off, then drain in order.
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1, 1'($urandom), rand_addr(), rand_data(), 0);
        chk("full_count", 64'(o_count), 64'(DEPTH));
        chk("full_ready", 64'(o_req_ready), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            cycle(0, 0, 0, 0, 1);
        chk("drained_count", 64'(o_count), 64'd0);

        // Steady push and pop at occupancy 2.
        cycle(1, 0, rand_addr(), rand_data(), 0);
        cycle(1, 1, rand_addr(), rand_data(), 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1'($urandom), rand_addr(), rand_data(), 1);
            chk("steady_count", 64'(o_count), 64'd2);
        end

        // Out-of-range address while one entry is held.
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 32'h0800_0000, rand_data(), 0);
        chk("oor_pulse", 64'(o_addr_err), 64'd1);
        chk("oor_count", 64'(o_count), 64'd1);
        cycle(0, 0, 0, 0, 0);
        chk("oor_pulse_end", 64'(o_addr_err), 64'd0);
        for (int i = 0; i < 2; i++)
            cycle(0, 0, 0, 0, 1);

        // Reset with three entries queued, then resume.
        for (int i = 0; i < 3; i++)
            cycle(1, 1'($urandom), rand_addr(), rand_data(), 0);
        do_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, rand_addr(), rand_data(), 0);
        cycle(1, 1, rand_addr(), rand_data(), 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Random traffic well past several pointer wraps.
        for (int i = 0; i < 40 * DEPTH; i++) begin
            logic [31:0] a;
            a = rand_addr();
            if ($urandom_range(7) == 0) a[27 + $urandom_range(4)] = 1'b1;
            cycle(1'($urandom_range(3) != 0), 1'($urandom), a, rand_data(),
                  1'($urandom_range(1)));
        end
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(0, 0, 0, 0, 1);
        chk("final_count", 64'(o_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
